// File: rtl/pueo_meta_pkg.sv
// Shared types and the beam-to-metadata group map for the beam metadata accumulator.
// Group m holds every beam b with b%8==m; beams 40..47 also feed group (b+1)%8.
package pueo_meta_pkg;

    localparam int NMETA     = 8;
    localparam int GROUP_MAX = 22;
    localparam int UNUSED    = 255;

    // Entries >= NBEAMS of the instantiating module contribute nothing.
    localparam int META_INDICES [NMETA][GROUP_MAX] = '{
        '{0, 8, 16, 24, 32, 40, 47, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{1, 9, 17, 25, 33, 41, 40, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{2, 10, 18, 26, 34, 42, 41, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{3, 11, 19, 27, 35, 43, 42, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{4, 12, 20, 28, 36, 44, 43, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{5, 13, 21, 29, 37, 45, 44, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{6, 14, 22, 30, 38, 46, 45, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{7, 15, 23, 31, 39, 47, 46, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255}
    };

    typedef struct packed {
        logic [NMETA-1:0] meta;
        logic [3:0]       merged;
    } meta_event_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } fsm_state_t;

    function automatic logic [3:0] sat15_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/beam_meta_fifo.sv
// First-word-fall-through event FIFO; the head is presented whenever non-empty and reads as 0 when empty.
// A push into a full FIFO is accepted only if the head is popped on the same edge.
module beam_meta_fifo
    import pueo_meta_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  meta_event_t data_i,
    input  logic        pop_i,
    output meta_event_t data_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int AW = $clog2(DEPTH);

    meta_event_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/beam_meta_accumulator.sv
// Collapses beam triggers into metadata groups, accumulates them over a window opened by each trigger,
// and queues one {meta, merged} event per window toward the readout link.
module beam_meta_accumulator
    import pueo_meta_pkg::*;
#(
    parameter int NBEAMS     = 48,
    parameter int WINDOW_LEN = 4,
    parameter int DEPTH      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NBEAMS-1:0] beam_i,
    input  logic              trig_i,
    input  logic              clr_ovf_i,
    output logic [NMETA-1:0]  meta_o,
    output logic [3:0]        merged_o,
    output logic              meta_valid_o,
    input  logic              meta_ready_i,
    output logic              trig_o,
    output logic              ovf_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [3:0] CNT_INIT = 4'(WINDOW_LEN - 1);

    logic [255:0]      w_beam_ext;
    logic [NMETA-1:0]  w_grp;
    logic [NMETA-1:0]  r_grp;
    logic              r_trig_d;
    fsm_state_t        r_state;
    logic [NMETA-1:0]  r_acc;
    logic [3:0]        r_merged;
    logic [3:0]        r_cnt;
    logic              r_trig_o;
    logic              r_ovf;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    meta_event_t       w_wr_evt;
    meta_event_t       w_head;

    // Zero-extended so unused map entries (>= NBEAMS) read as 0.
    assign w_beam_ext = 256'(beam_i);

    always_comb begin
        w_grp = '0;
        for (int m = 0; m < NMETA; m++) begin
            for (int k = 0; k < GROUP_MAX; k++) begin
                if (META_INDICES[m][k] < NBEAMS) begin
                    w_grp[m] = w_grp[m] | w_beam_ext[8'(META_INDICES[m][k])];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grp    <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_grp    <= w_grp;
            r_trig_d <= trig_i;
        end
    end

    // A trigger seen while pushing opens the next window straight away, so none is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_merged <= '0;
            r_cnt    <= '0;
            r_trig_o <= 1'b0;
        end else begin
            r_trig_o <= (r_state == PUSH);
            case (r_state)
                IDLE, PUSH: begin
                    if (r_trig_d) begin
                        r_acc    <= r_grp;
                        r_merged <= '0;
                        r_cnt    <= CNT_INIT;
                        r_state  <= (WINDOW_LEN == 1) ? PUSH : ACCUM;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc | r_grp;
                    if (r_trig_d) begin
                        r_merged <= sat15_inc(r_merged);
                    end
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= PUSH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push          = (r_state == PUSH);
    assign w_pop           = meta_valid_o & meta_ready_i;
    assign w_wr_evt.meta   = r_acc;
    assign w_wr_evt.merged = r_merged;

    beam_meta_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_wr_evt),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    // A drop wins over a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_push & w_full & ~w_pop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign meta_o       = w_head.meta;
    assign merged_o     = w_head.merged;
    assign meta_valid_o = ~w_empty;
    assign trig_o       = r_trig_o;
    assign ovf_o        = r_ovf;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_beam_meta_accumulator.sv
// Randomized and directed bench for beam_meta_accumulator with a window-level reference model
// feeding an expected-event queue that a free-running monitor consumes.
module tb_beam_meta_accumulator;

    localparam int NB    = 48;
    localparam int WL    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] beam = '0;
    logic          trig = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          ready = 1'b0;
    logic [7:0]    meta_o;
    logic [3:0]    merged_o;
    logic          meta_valid_o;
    logic          trig_o;
    logic          ovf_o;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    beam_meta_accumulator #(
        .NBEAMS     (NB),
        .WINDOW_LEN (WL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .beam_i       (beam),
        .trig_i       (trig),
        .clr_ovf_i    (clr_ovf),
        .meta_o       (meta_o),
        .merged_o     (merged_o),
        .meta_valid_o (meta_valid_o),
        .meta_ready_i (ready),
        .trig_o       (trig_o),
        .ovf_o        (ovf_o),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Group membership rule written independently of the RTL lookup table.
    function automatic logic [7:0] grp_of(input logic [NB-1:0] b);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < NB; i++) begin
            if (b[i]) begin
                g[i % 8] = 1'b1;
                if (i >= 40) g[(i + 1) % 8] = 1'b1;
            end
        end
        return g;
    endfunction

    // Reference model: a trigger at edge t opens a window over beam samples t..t+WL-1 when no window
    // is open; triggers at t+1..t+WL-1 merge; the event is written at edge t+WL+1.
    logic [11:0] exp_q[$];
    int          open_q[$];
    logic [7:0]  grp_hist [64];
    bit          trig_hist [64];
    int          edge_n, next_free, model_occ;
    bit          exp_trig, exp_ovf;
    bit          m_push, m_pop, m_drop;
    logic [7:0]  m_meta;
    int          m_mrg, m_open;

    always @(posedge clk) begin
        if (rst) begin
            edge_n = 0; next_free = 0; model_occ = 0;
            exp_trig = 0; exp_ovf = 0;
            open_q.delete(); exp_q.delete();
        end else begin
            grp_hist[edge_n % 64]  = grp_of(beam);
            trig_hist[edge_n % 64] = trig;
            if (trig && edge_n >= next_free) begin
                open_q.push_back(edge_n);
                next_free = edge_n + WL;
            end
            m_push = 0;
            if (open_q.size() > 0 && open_q[0] + WL + 1 == edge_n) begin
                m_open = open_q.pop_front();
                m_meta = '0;
                m_mrg  = 0;
                for (int j = 0; j < WL; j++) m_meta |= grp_hist[(m_open + j) % 64];
                for (int j = 1; j < WL; j++) if (trig_hist[(m_open + j) % 64]) m_mrg++;
                if (m_mrg > 15) m_mrg = 15;
                m_push = 1;
            end
            m_pop  = (model_occ > 0) && ready;
            m_drop = m_push && (model_occ == DEPTH) && !m_pop;
            if (m_push && !m_drop) begin
                exp_q.push_back({m_meta, 4'(m_mrg)});
                model_occ++;
            end
            if (m_pop) model_occ--;
            exp_trig = m_push;
            if (m_drop) exp_ovf = 1;
            else if (clr_ovf) exp_ovf = 0;
            edge_n++;
        end
    end

    // Monitor: samples away from the active edge; a head seen with ready high is consumed.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("valid", 32'(meta_valid_o), 32'(model_occ > 0));
                chk("trig_o", 32'(trig_o), 32'(exp_trig));
                chk("ovf", 32'(ovf_o), 32'(exp_ovf));
                if (meta_valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: got meta %0h merged %0h expected none", meta_o, merged_o);
                    end else begin
                        chk("meta", 32'(meta_o), 32'(exp_q[0][11:4]));
                        chk("merged", 32'(merged_o), 32'(exp_q[0][3:0]));
                        if (ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("empty_head", 32'({merged_o, meta_o}), 32'(0));
                end
            end
        end
    end

    task automatic step(input logic t, input logic [NB-1:0] b);
        @(negedge clk);
        trig = t;
        beam = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    function automatic logic [NB-1:0] rand_beam();
        logic [NB-1:0] b;
        b = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        return b;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(meta_valid_o), 32'(0));
        chk("rst_trig_o", 32'(trig_o), 32'(0));
        chk("rst_ovf", 32'(ovf_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: no triggers for 100 clocks
        for (int i = 0; i < 100; i++) begin
            step(1'b0, rand_beam());
            ready = 1'($urandom_range(0, 1));
        end

        // 2: group 2 beam at E0, group 5 beam at E3
        ready = 1'b0;
        step(1'b1, 48'h4);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b0, 48'h20);
        step(1'b0, '0);
        step(1'b0, '0);
        @(negedge clk);
        #1;
        chk("t2_valid", 32'(meta_valid_o), 32'(1));
        chk("t2_meta", 32'(meta_o), 32'(8'h24));
        chk("t2_merged", 32'(merged_o), 32'(0));
        chk("t2_trig_o", 32'(trig_o), 32'(1));
        ready = 1'b1;
        idle(8);

        // 3: three trigger cycles merge; beam after the window is excluded
        ready = 1'b0;
        step(1'b1, '0);
        step(1'b1, '0);
        step(1'b1, '0);
        step(1'b0, '0);
        step(1'b0, 48'h4);
        step(1'b0, '0);
        @(negedge clk);
        #1;
        chk("t3_valid", 32'(meta_valid_o), 32'(1));
        chk("t3_meta", 32'(meta_o), 32'(0));
        chk("t3_merged", 32'(merged_o), 32'(2));
        ready = 1'b1;
        idle(8);

        // 4: second trigger lands in the PUSH cycle
        step(1'b1, rand_beam());
        for (int i = 0; i < 3; i++) step(1'b0, rand_beam());
        step(1'b1, rand_beam());
        for (int i = 0; i < 10; i++) step(1'b0, rand_beam());

        // 5: fill the FIFO, overflow, clear, drain
        ready = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step(1'b1, rand_beam());
            for (int i = 0; i < 7; i++) step(1'b0, rand_beam());
        end
        #1;
        chk("t5_ovf_set", 32'(ovf_o), 32'(1));
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        #1;
        chk("t5_ovf_clr", 32'(ovf_o), 32'(0));
        ready = 1'b1;
        idle(8);
        #1;
        chk("t5_drained", 32'(meta_valid_o), 32'(0));
        chk("t5_exp_q_empty", 32'(exp_q.size()), 32'(0));

        // 6: reset mid-window with two events queued
        ready = 1'b0;
        for (int e = 0; e < 2; e++) begin
            step(1'b1, rand_beam());
            for (int i = 0; i < 7; i++) step(1'b0, rand_beam());
        end
        step(1'b1, rand_beam());
        step(1'b0, rand_beam());
        step(1'b0, rand_beam());
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(meta_valid_o), 32'(0));
        chk("t6_head", 32'({merged_o, meta_o}), 32'(0));
        chk("t6_trig_o", 32'(trig_o), 32'(0));
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        #1;
        chk("t6_no_event", 32'(meta_valid_o), 32'(0));

        // Random traffic with backpressure and occasional overflow clears
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 99) < 18), rand_beam());
            ready   = 1'($urandom_range(0, 99) < 60);
            clr_ovf = 1'($urandom_range(0, 99) < 3);
        end
        clr_ovf = 1'b0;
        ready   = 1'b1;
        idle(30);
        #1;
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
